// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, up to MAX_BURST beats per grant.
// Optional per-requester accepted-beat counters are built when FIFO_PUSH_ARB_CNT_EN is defined.
module fifo_push_arb #(
  parameter int WIDTH     = 4,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  input  logic                     fifo_full,
  output logic [N_REQ-1:0]         gnt,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     o_dbg_state
`ifdef FIFO_PUSH_ARB_CNT_EN
  ,
  input  logic                     cnt_clr,
  output logic [N_REQ*16-1:0]      beat_cnt_o
`endif
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  // Requester handshake: a requester holds req high and its data word stable
  // until it sees its gnt bit; gnt high means the word is pushed in that cycle.
  state_t          r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last;
  logic [CW-1:0]   r_beat_cnt;

  logic            w_req_owner;
  logic            w_beat;
  logic            w_last_beat;
  logic [OW-1:0]   w_pick;
  logic            w_found;

  assign w_req_owner = req[r_owner];
  assign w_beat      = (r_state == S_BURST) && w_req_owner && !fifo_full;
  assign w_last_beat = w_beat && (r_beat_cnt == CW'(MAX_BURST - 1));

  // First requester found scanning upward from last+1, wrapping modulo N_REQ.
  always_comb begin
    logic [OW-1:0] idx;
    w_pick  = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = OW'((int'(r_last) + 1 + k) % N_REQ);
      if (!w_found && req[idx]) begin
        w_pick  = idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_last     <= OW'(N_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (!w_req_owner) begin
            r_state <= S_IDLE;
            r_last  <= r_owner;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_last  <= r_owner;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt         = w_beat ? (N_REQ'(1) << r_owner) : '0;
  assign fifo_push   = w_beat;
  assign fifo_data   = (r_state == S_BURST) ? data[r_owner*WIDTH +: WIDTH] : '0;
  assign owner       = r_owner;
  assign busy        = (r_state == S_BURST);
  assign o_dbg_state = r_state;

`ifdef FIFO_PUSH_ARB_CNT_EN
  logic [15:0] r_cnt [N_REQ];

  // Clear takes priority over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cnt_clr)
          r_cnt[i] <= '0;
        else if (gnt[i] && (r_cnt[i] != 16'hFFFF))
          r_cnt[i] <= r_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
    assign beat_cnt_o[g*16 +: 16] = r_cnt[g];
  end
`endif

endmodule
